receive_connector: RTL and testbench
====================================

# receive_connector

Host-to-AGC direction of the UART debug link. Consumes bytes from `uart_rx` and reassembles self-synchronising 3-byte frames into 15-bit I/O-register writes toward `core`. Drives a one-cycle write strobe with a register select and data word. Resynchronises after garbage, overlapping headers, stalled frames and out-of-range register indices.

## Interface

**Parameters**
- `NUM_IO_REGS`, default 32: count of valid register indices. Index must be less than this value; legal range is 1..64.
- `TIMEOUT_CYCLES`, default 50000: maximum idle gap between bytes inside one frame, in clocks.

**Ports** (name, direction, width, meaning)
- `clock` input 1: single clock. All logic is clocked on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `uart_rx_valid` input 1: one-cycle pulse; `uart_rx_data` is valid in that cycle.
- `uart_rx_data` input 8: received byte.
- `io_reg_wr_en` output 1: one-cycle write strobe.
- `write_sel` output `IO_reg_t`: target register. Valid while `io_reg_wr_en` is high.
- `io_reg_wr_data` output 15: write data. Valid while `io_reg_wr_en` is high.
- `frame_err` output 1: one-cycle pulse for each dropped byte or dropped frame.
- `err_count` output 8: saturating count of `frame_err` pulses.

## Operation

**Frame format** (bit 7 is the sync marker)
- Header byte: `{1'b1, d[14], idx[5:0]}`.
- Byte 1: `{1'b0, d[13:7]}`.
- Byte 2: `{1'b0, d[6:0]}`.

**States** (`rx_state_t`)
- IDLE
  - Header byte: latch `d[14]` and `idx`, go to GOT_HDR.
  - Data byte: discard it, pulse `frame_err`.
- GOT_HDR
  - Data byte: latch `d[13:7]`, go to GOT_B1.
  - Header byte: restart the frame from this header (relatch fields, stay in GOT_HDR), pulse `frame_err`.
- GOT_B1
  - Data byte: latch `d[6:0]`, go to WRITE.
  - Header byte: restart as in GOT_HDR, go to GOT_HDR, pulse `frame_err`.
- WRITE (lasts one cycle)
  - If `idx < NUM_IO_REGS`: assert `io_reg_wr_en`, drive `write_sel = IO_reg_t'(idx)` and the assembled word.
  - Otherwise: no write, pulse `frame_err`.
  - Always return to IDLE.
  - A byte arriving in this cycle is processed exactly as in IDLE and must not be lost.

**Gap timer**
- Cleared on every accepted byte. Counts only in GOT_HDR and GOT_B1.
- Reaching `TIMEOUT_CYCLES` returns the FSM to IDLE, pulses `frame_err` and discards partial data.
- If the timeout and `uart_rx_valid` occur in the same cycle, the byte wins and the timeout is ignored.

**Error counter**
- `err_count` increments on each `frame_err` and saturates at 255.
- At most one `frame_err` per cycle.

## Timing

- **Reset:** FSM to IDLE, gap timer 0, `io_reg_wr_en = 0`, `frame_err = 0`, `err_count = 0`, `write_sel = 0`, `io_reg_wr_data = 0`.
- **Reset mid-frame:** the partial frame is discarded and no write is issued.
- **Write latency:** if byte 2 is valid in cycle N, `io_reg_wr_en` is high in cycle N+1 only. Back-to-back frames are supported with no dead cycle.
- **Error latency:**
  - `frame_err` for a bad byte is registered and appears in cycle N+1.
  - For an out-of-range index it appears in the WRITE cycle.
  - For a timeout it appears in the cycle after the timer reaches `TIMEOUT_CYCLES`.
- **Data outputs:** `write_sel` and `io_reg_wr_data` hold their last values between strobes.
- **Backpressure:** none. The core accepts a write every cycle.

## Structure

- `rx_state_t`, `RX_HDR_MARK` (bit 7) and the field positions live in `internal_defines.vh`, alongside `IO_reg_t`. The TX side's frame packer uses the same constants.
- One sub-module, `rx_gap_timer`. Inputs: clear, enable. Output: expired. Width `$clog2(TIMEOUT_CYCLES+1)`.
- Estimated size: about 200 lines of RTL.

## Test plan

1. **Nominal write:** bytes 0x83, 0x29, 0x65 -> one `io_reg_wr_en` pulse with `write_sel = 3`, `io_reg_wr_data = 15'o12345`. No `frame_err`.
2. **High bit and back-to-back frames:** 0xC5, 0x7F, 0x7F sent back-to-back with a second frame starting in the WRITE cycle -> `write_sel = 5`, `io_reg_wr_data = 15'o77777`; the second frame also completes.
3. **Resync:** 0x29 in IDLE, then 0x83, 0x83, 0x29, 0x65 -> `err_count = 2` and exactly one write of 15'o12345 to index 3.
4. **Timeout:** with `TIMEOUT_CYCLES = 20`, send 0x83, 0x29, wait 25 clocks, then send 0x65 -> one timeout `frame_err`, the trailing data byte is dropped (total `err_count = 2`), no write.
5. **Out-of-range index:** with `NUM_IO_REGS = 32`, send 0xA0, 0x00, 0x00 (idx 32) -> no write, `frame_err` pulses in the WRITE cycle.
6. **Reset mid-frame:** assert `reset_n = 0` after 0x83, 0x29, then send 0x65 -> no write, `err_count = 1` (stray data byte after reset).

Source files
------------

// File: rtl/receive_connector_pkg.sv
// receive_connector_pkg
// Shared definitions for the host-to-AGC UART debug link. The TX-side frame
// packer uses the same marker bit and field positions, so keep them here.
//   rx_state_t   : receive FSM states
//   RX_HDR_MARK  : bit that distinguishes a header byte from a data byte
//   IO_reg_t     : I/O register select carried in the header
package receive_connector_pkg;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_GOT_HDR = 2'd1,
        RX_GOT_B1  = 2'd2,
        RX_WRITE   = 2'd3
    } rx_state_t;

    localparam int RX_HDR_MARK    = 7;   // 1 = header byte, 0 = data byte
    localparam int RX_HDR_D14_BIT = 6;   // header carries d[14] here
    localparam int RX_IDX_W       = 6;   // header bits [5:0] are the index
    localparam int RX_PAYLOAD_W   = 7;   // data bytes carry 7 payload bits
    localparam int IO_DATA_W      = 15;

    typedef logic [RX_IDX_W-1:0] IO_reg_t;

    function automatic logic is_header(input logic [7:0] b);
        return b[RX_HDR_MARK];
    endfunction

endpackage

// File: rtl/receive_connector_rx_gap_timer.sv
// rx_gap_timer
// Counts idle clocks between bytes of one frame and flags when the gap has
// reached TIMEOUT_CYCLES. The count parks at the limit so expired stays high
// until the owner clears it.
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : restart the count from zero (has priority over enable)
//   enable         : advance the count this cycle
//   expired        : count has reached TIMEOUT_CYCLES
module rx_gap_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == CNT_MAX);

endmodule

// File: rtl/receive_connector.sv
// receive_connector
// Reassembles self-synchronising 3-byte UART frames into 15-bit I/O register
// writes toward the core.
//   Header : {1, d[14], idx[5:0]}   Byte 1 : {0, d[13:7]}   Byte 2 : {0, d[6:0]}
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   uart_rx_valid/_data   : one-cycle received-byte strobe and byte
//   io_reg_wr_en          : one-cycle write strobe (cycle after byte 2)
//   write_sel, io_reg_wr_data : write target and word, held between strobes
//   frame_err             : one-cycle pulse per dropped byte or frame
//   err_count             : saturating count of frame_err pulses
module receive_connector
    import receive_connector_pkg::*;
#(
    parameter int NUM_IO_REGS    = 32,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 uart_rx_valid,
    input  logic [7:0]           uart_rx_data,
    output logic                 io_reg_wr_en,
    output IO_reg_t              write_sel,
    output logic [IO_DATA_W-1:0] io_reg_wr_data,
    output logic                 frame_err,
    output logic [7:0]           err_count
);

    rx_state_t                 state_reg, state_next;
    logic                      d14_reg, d14_next;
    IO_reg_t                   idx_reg, idx_next;
    logic [RX_PAYLOAD_W-1:0]   d_hi_reg, d_hi_next;
    logic                      wr_en_reg, wr_en_next;
    IO_reg_t                   sel_reg, sel_next;
    logic [IO_DATA_W-1:0]      data_reg, data_next;
    logic                      err_reg, err_next;
    logic [7:0]                err_count_reg;

    logic in_frame;
    logic gap_expired;
    logic rx_hdr;
    logic idx_in_range;

    assign in_frame     = (state_reg == RX_GOT_HDR) || (state_reg == RX_GOT_B1);
    assign rx_hdr       = is_header(uart_rx_data);
    // Widen by one bit so NUM_IO_REGS = 64 compares correctly.
    assign idx_in_range = ({1'b0, idx_reg} < (RX_IDX_W + 1)'(NUM_IO_REGS));

    // Outside a frame the timer is held at zero, so it only ever measures
    // gaps between bytes of the same frame.
    rx_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (uart_rx_valid || !in_frame),
        .enable (in_frame),
        .expired(gap_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= RX_IDLE;
            d14_reg       <= 1'b0;
            idx_reg       <= '0;
            d_hi_reg      <= '0;
            wr_en_reg     <= 1'b0;
            sel_reg       <= '0;
            data_reg      <= '0;
            err_reg       <= 1'b0;
            err_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            d14_reg   <= d14_next;
            idx_reg   <= idx_next;
            d_hi_reg  <= d_hi_next;
            wr_en_reg <= wr_en_next;
            sel_reg   <= sel_next;
            data_reg  <= data_next;
            err_reg   <= err_next;
            if (err_next && (err_count_reg != 8'hFF)) begin
                err_count_reg <= err_count_reg + 8'd1;
            end
        end
    end

    // Byte 2 is assembled straight into the output registers, so the strobe
    // (or the out-of-range error) lands in the WRITE cycle and that cycle is
    // free to accept the next header, giving back-to-back frames.
    always_comb begin
        state_next = state_reg;
        d14_next   = d14_reg;
        idx_next   = idx_reg;
        d_hi_next  = d_hi_reg;
        wr_en_next = 1'b0;
        sel_next   = sel_reg;
        data_next  = data_reg;
        err_next   = 1'b0;

        case (state_reg)
            RX_IDLE, RX_WRITE: begin
                state_next = RX_IDLE;
                if (uart_rx_valid) begin
                    if (rx_hdr) begin
                        d14_next   = uart_rx_data[RX_HDR_D14_BIT];
                        idx_next   = uart_rx_data[RX_IDX_W-1:0];
                        state_next = RX_GOT_HDR;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            RX_GOT_HDR, RX_GOT_B1: begin
                if (uart_rx_valid) begin
                    if (rx_hdr) begin
                        // Overlapping header: abandon the partial frame and
                        // restart from this one.
                        d14_next   = uart_rx_data[RX_HDR_D14_BIT];
                        idx_next   = uart_rx_data[RX_IDX_W-1:0];
                        state_next = RX_GOT_HDR;
                        err_next   = 1'b1;
                    end else if (state_reg == RX_GOT_HDR) begin
                        d_hi_next  = uart_rx_data[RX_PAYLOAD_W-1:0];
                        state_next = RX_GOT_B1;
                    end else begin
                        state_next = RX_WRITE;
                        if (idx_in_range) begin
                            wr_en_next = 1'b1;
                            sel_next   = idx_reg;
                            data_next  = {d14_reg, d_hi_reg, uart_rx_data[RX_PAYLOAD_W-1:0]};
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end else if (gap_expired) begin
                    // A byte in the same cycle takes precedence (branch above).
                    state_next = RX_IDLE;
                    err_next   = 1'b1;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign io_reg_wr_en   = wr_en_reg;
    assign write_sel      = sel_reg;
    assign io_reg_wr_data = data_reg;
    assign frame_err      = err_reg;
    assign err_count      = err_count_reg;

endmodule

// File: tb/tb_receive_connector.sv
// tb_receive_connector
// Randomised and directed byte streams checked cycle by cycle against a
// frame-level reference model (bytes collected per frame, silence counter).
module tb_receive_connector;
    import receive_connector_pkg::*;

    localparam int NUM_REGS = 32;
    localparam int TMO      = 20;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          uart_rx_valid = 1'b0;
    logic [7:0]    uart_rx_data = 8'h00;
    logic          io_reg_wr_en;
    IO_reg_t       write_sel;
    logic [14:0]   io_reg_wr_data;
    logic          frame_err;
    logic [7:0]    err_count;

    int checks = 0;
    int errors = 0;
    int dut_writes = 0;

    // Reference model state
    int m_have;      // bytes of the current frame collected (0..2)
    int m_silent;    // idle cycles since last byte while a frame is open
    int m_d14, m_idx, m_hi;
    int e_wr, e_sel, e_data, e_err, e_cnt;

    always #5 clock = ~clock;

    receive_connector #(
        .NUM_IO_REGS(NUM_REGS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .io_reg_wr_en  (io_reg_wr_en),
        .write_sel     (write_sel),
        .io_reg_wr_data(io_reg_wr_data),
        .frame_err     (frame_err),
        .err_count     (err_count)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_have = 0; m_silent = 0; m_d14 = 0; m_idx = 0; m_hi = 0;
        e_wr = 0; e_sel = 0; e_data = 0; e_err = 0; e_cnt = 0;
    endfunction

    // One clock of the protocol: what the byte (or silence) does to the frame.
    function automatic void model_step(input logic v, input logic [7:0] b);
        e_wr = 0;
        e_err = 0;
        if (v) begin
            if (b[7]) begin
                if (m_have != 0) e_err = 1;
                m_have = 1;
                m_d14  = int'(b[6]);
                m_idx  = int'(b[5:0]);
            end else if (m_have == 0) begin
                e_err = 1;
            end else if (m_have == 1) begin
                m_hi   = int'(b[6:0]);
                m_have = 2;
            end else begin
                m_have = 0;
                if (m_idx < NUM_REGS) begin
                    e_wr   = 1;
                    e_sel  = m_idx;
                    e_data = m_d14 * 16384 + m_hi * 128 + int'(b[6:0]);
                end else begin
                    e_err = 1;
                end
            end
            m_silent = 0;
        end else if (m_have != 0) begin
            if (m_silent == TMO) begin
                m_have = 0;
                m_silent = 0;
                e_err = 1;
            end else begin
                m_silent++;
            end
        end
        if (e_err != 0 && e_cnt < 255) e_cnt++;
    endfunction

    task automatic cycle(input logic v, input logic [7:0] b);
        uart_rx_valid = v;
        uart_rx_data  = b;
        model_step(v, b);
        @(posedge clock);
        #1;
        uart_rx_valid = 1'b0;
        if (io_reg_wr_en) dut_writes++;
        check_val("wr_en", 32'(io_reg_wr_en), e_wr);
        check_val("frame_err", 32'(frame_err), e_err);
        check_val("err_count", 32'(err_count), e_cnt);
        check_val("write_sel", 32'(write_sel), e_sel);
        check_val("wr_data", 32'(io_reg_wr_data), e_data);
        if (v)
            $display("byte 0x%02h -> wr_en=%0b sel=%0d data=%05o err=%0b cnt=%0d",
                     b, io_reg_wr_en, write_sel, io_reg_wr_data, frame_err, err_count);
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        uart_rx_valid = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        check_val("rst_wr_en", 32'(io_reg_wr_en), 0);
        check_val("rst_err", 32'(frame_err), 0);
        check_val("rst_cnt", 32'(err_count), 0);
        check_val("rst_sel", 32'(write_sel), 0);
        check_val("rst_data", 32'(io_reg_wr_data), 0);
        reset_n = 1'b1;
        idle(2);
    endtask

    initial begin
        int base_cnt, base_wr;
        model_reset();
        apply_reset();

        // Nominal write
        send(8'h83); send(8'h29); send(8'h65);
        check_val("t1_wr", 32'(io_reg_wr_en), 1);
        check_val("t1_sel", 32'(write_sel), 3);
        check_val("t1_data", 32'(io_reg_wr_data), 32'o12345);
        idle(2);

        // High bit, back-to-back frame starting in the WRITE cycle
        send(8'hC5); send(8'h7F); send(8'h7F);
        check_val("t2_sel", 32'(write_sel), 5);
        check_val("t2_data", 32'(io_reg_wr_data), 32'o77777);
        send(8'h83); send(8'h29); send(8'h65);
        check_val("t2b_wr", 32'(io_reg_wr_en), 1);
        check_val("t2b_data", 32'(io_reg_wr_data), 32'o12345);
        idle(2);

        // Resync after garbage and overlapping header
        base_cnt = int'(err_count);
        base_wr  = dut_writes;
        send(8'h29); send(8'h83); send(8'h83); send(8'h29); send(8'h65);
        check_val("t3_cnt", 32'(err_count), 32'(base_cnt + 2));
        check_val("t3_writes", 32'(dut_writes - base_wr), 1);
        idle(2);

        // Timeout drops the partial frame and the late byte
        base_cnt = int'(err_count);
        base_wr  = dut_writes;
        send(8'h83); send(8'h29); idle(25); send(8'h65);
        check_val("t4_cnt", 32'(err_count), 32'(base_cnt + 2));
        check_val("t4_writes", 32'(dut_writes - base_wr), 0);
        idle(2);

        // Gap boundary: 20 idle cycles survive, 21 time out
        send(8'h81); idle(TMO); send(8'h01); idle(TMO); send(8'h02);
        idle(2);
        send(8'h81); idle(TMO + 1); send(8'h01);
        idle(2);

        // Out-of-range index
        base_wr = dut_writes;
        send(8'hA0); send(8'h00); send(8'h00);
        check_val("t5_err", 32'(frame_err), 1);
        check_val("t5_wr", 32'(io_reg_wr_en), 0);
        idle(2);

        // Reset mid-frame
        send(8'h83); send(8'h29);
        apply_reset();
        base_wr = dut_writes;
        send(8'h65);
        idle(1);
        check_val("t6_cnt", 32'(err_count), 1);
        check_val("t6_writes", 32'(dut_writes - base_wr), 0);

        // Randomised traffic: mostly well-formed frames with random gaps,
        // some stray bytes, truncated frames and long stalls.
        for (int f = 0; f < 300; f++) begin
            int kind;
            kind = int'($urandom_range(0, 9));
            if (kind < 6) begin
                send({1'b1, 1'($urandom), 6'($urandom_range(0, 40))});
                idle(int'($urandom_range(0, 3)));
                send({1'b0, 7'($urandom)});
                idle(int'($urandom_range(0, 3)));
                send({1'b0, 7'($urandom)});
            end else if (kind < 8) begin
                send(8'($urandom));
            end else begin
                idle(int'($urandom_range(TMO - 1, TMO + 3)));
            end
            idle(int'($urandom_range(0, 2)));
        end

        // Saturate the error counter with stray data bytes
        for (int i = 0; i < 270; i++) send({1'b0, 7'($urandom)});
        check_val("sat_cnt", 32'(err_count), 255);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
